// File: rtl/traffic_pkg.sv
// traffic_pkg: shared definitions for the intersection phase scheduler.
//   - light codes driven per approach on the packed light bus
//   - controller state encoding
//   - approach indices (bit positions in req/grant/pending; 2-bit slot in lights)
//   - round-robin search helper used at the all-red exit
package traffic_pkg;

  typedef enum logic [1:0] {
    LIGHT_RED    = 2'b00,
    LIGHT_YELLOW = 2'b01,
    LIGHT_GREEN  = 2'b10
  } light_t;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_ALL_RED = 2'd1,
    ST_GREEN   = 2'd2,
    ST_YELLOW  = 2'd3
  } state_t;

  // Approach index == bit position in req/grant/pending.
  localparam logic [1:0] APP_N = 2'd3;
  localparam logic [1:0] APP_E = 2'd2;
  localparam logic [1:0] APP_S = 2'd1;
  localparam logic [1:0] APP_W = 2'd0;

  // Service rotation is N->E->S->W, i.e. decreasing index. Search
  // cur-1, cur-2, cur-3, cur (mod 4); with nothing pending, keep cur.
  function automatic logic [1:0] rr_next(input logic [1:0] cur,
                                         input logic [3:0] pend);
    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;
    pick  = cur;
    found = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = cur - 2'(k);
      if (!found && pend[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// sec_tick_gen: prescaler producing a one-cycle tick every CLK_HZ cycles.
// The first tick occurs CLK_HZ cycles after reset deassertion.
// Ports:
//   clk   in  clock
//   reset in  asynchronous, active-low reset
//   tick  out one-cycle pulse, period CLK_HZ cycles
module sec_tick_gen #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler: demand-driven green arbiter for a
// four-approach intersection (N/E/S/W). Startup all-yellow flash, then
// round-robin service of latched demand with min/max green, yellow and
// all-red clearance. Rests in green while no other approach is waiting.
// Optional macro PREEMPT_EN adds emergency preemption ports.
// Ports:
//   clk          in  clock
//   reset        in  asynchronous, active-low reset
//   req[3:0]     in  vehicle detectors, bit3=N, 2=E, 1=S, 0=W
//   preempt      in  (PREEMPT_EN) preemption request, level
//   preempt_dir  in  (PREEMPT_EN) 0=N, 1=E, 2=S, 3=W
//   lights[7:0]  out {N,E,S,W} 2-bit codes: red=00, yellow=01, green=10
//   grant[3:0]   out one-hot served approach in GREEN/YELLOW, else 0
//   pending[3:0] out latched demand per approach
module intersection_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned STARTUP_SEC = 3,
  parameter int unsigned MIN_GREEN   = 5,
  parameter int unsigned MAX_GREEN   = 20,
  parameter int unsigned YELLOW_SEC  = 2,
  parameter int unsigned CLEAR_SEC   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
`ifdef PREEMPT_EN
  input  logic       preempt,
  input  logic [1:0] preempt_dir,
`endif
  output logic [7:0] lights,
  output logic [3:0] grant,
  output logic [3:0] pending
);

  logic       tick;
  state_t     state, state_n;
  logic [1:0] cur, cur_n;
  logic [7:0] elapsed, elapsed_n;
  logic [3:0] pending_n;
  logic [7:0] ticks_in;
  logic [31:0] ticks32;
  logic       other_pend;
  logic       preempt_act;
  logic [1:0] preempt_idx;
  logic [3:0] clr_mask;

  sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

`ifdef PREEMPT_EN
  assign preempt_act = preempt;
  // preempt_dir numbers approaches N..W as 0..3, opposite to bit index.
  assign preempt_idx = 2'd3 - preempt_dir;
`else
  assign preempt_act = 1'b0;
  assign preempt_idx = APP_N;
`endif

  // Tick count including the current tick: a state whose duration is D
  // ticks is left on the D-th tick after entry.
  assign ticks_in   = (elapsed == 8'hFF) ? 8'hFF : elapsed + 8'd1;
  assign ticks32    = {24'd0, ticks_in};
  assign other_pend = |(pending & ~onehot4(cur));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_INIT;
      cur     <= APP_N;
      elapsed <= '0;
      pending <= '0;
    end else begin
      state   <= state_n;
      cur     <= cur_n;
      elapsed <= elapsed_n;
      pending <= pending_n;
    end
  end

  always_comb begin
    state_n = state;
    cur_n   = cur;
    case (state)
      ST_INIT: begin
        if (tick && ticks32 >= STARTUP_SEC) state_n = ST_ALL_RED;
      end
      ST_ALL_RED: begin
        if (tick && ticks32 >= CLEAR_SEC) begin
          state_n = ST_GREEN;
          cur_n   = preempt_act ? preempt_idx : rr_next(cur, pending);
        end
      end
      ST_GREEN: begin
        if (preempt_act) begin
          // Preempted direction holds; any other green yields immediately.
          if (preempt_idx != cur) state_n = ST_YELLOW;
        end else if (tick && ticks32 >= MIN_GREEN && other_pend &&
                     (!req[cur] || ticks32 >= MAX_GREEN)) begin
          state_n = ST_YELLOW;
        end
      end
      ST_YELLOW: begin
        if (tick && ticks32 >= YELLOW_SEC) state_n = ST_ALL_RED;
      end
      default: state_n = ST_INIT;
    endcase

    if (state_n != state) begin
      elapsed_n = '0;
    end else if (tick) begin
      elapsed_n = ticks_in;
    end else begin
      elapsed_n = elapsed;
    end

    // The approach entering green drops its demand even if req is set now.
    clr_mask = '0;
    if (state_n == ST_GREEN && state != ST_GREEN) clr_mask = onehot4(cur_n);
    pending_n = (pending | (req & ~grant)) & ~clr_mask;
  end

  always_comb begin
    lights = '0;
    grant  = '0;
    case (state)
      ST_INIT: lights = {4{LIGHT_YELLOW}};
      ST_GREEN: begin
        lights[{cur, 1'b0} +: 2] = LIGHT_GREEN;
        grant[cur]               = 1'b1;
      end
      ST_YELLOW: begin
        lights[{cur, 1'b0} +: 2] = LIGHT_YELLOW;
        grant[cur]               = 1'b1;
      end
      default: begin
        lights = '0;
        grant  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
module tb_intersection_phase_scheduler;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [7:0] lights;
  logic [3:0] grant;
  logic [3:0] pending;
`ifdef PREEMPT_EN
  logic       preempt;
  logic [1:0] preempt_dir;
`endif

  intersection_phase_scheduler #(.CLK_HZ(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
`ifdef PREEMPT_EN
    .preempt     (preempt),
    .preempt_dir (preempt_dir),
`endif
    .lights      (lights),
    .grant       (grant),
    .pending     (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         cycles;
    logic       rst;
    logic [3:0] req;
    logic       pre;
    logic [1:0] dir;
    logic [7:0] lights;
    logic [3:0] grant;
    logic [3:0] pend;
  } seg_t;

  typedef struct {
    string      name;
    logic [7:0] lights;
    logic [3:0] grant;
    logic [3:0] pend;
  } exp_t;

  seg_t segs[$];
  exp_t expq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 0;

  task automatic add(input string nm, input int n, input logic rst,
                     input logic [3:0] rq, input logic pr, input logic [1:0] dr,
                     input logic [7:0] l, input logic [3:0] g, input logic [3:0] p);
    seg_t s;
    s.name = nm; s.cycles = n; s.rst = rst; s.req = rq; s.pre = pr; s.dir = dr;
    s.lights = l; s.grant = g; s.pend = p;
    segs.push_back(s);
  endtask

  task automatic add_reset(input string nm);
    add(nm, 2, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h55, 4'b0000, 4'b0000);
  endtask

  task automatic add_startup(input string nm);
    add({nm, "_flash"}, 12, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h55, 4'b0000, 4'b0000);
    add({nm, "_clear"},  4, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 4'b0000, 4'b0000);
  endtask

  // Scoreboard monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (!done && expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      n_cmp++;
      if (lights !== e.lights || grant !== e.grant || pending !== e.pend) begin
        n_bad++;
        $display("FAIL %s: lights=%h grant=%b pending=%b, expected lights=%h grant=%b pending=%b",
                 e.name, lights, grant, pending, e.lights, e.grant, e.pend);
      end
    end
  end

  initial begin
    reset = 1'b0;
    req   = '0;
`ifdef PREEMPT_EN
    preempt     = 1'b0;
    preempt_dir = 2'd0;
`endif

    // Test 1: startup, then N rests in green with no demand.
    add_reset("t1_rst");
    add_startup("t1");
    add("t1_n_rest", 40, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h80, 4'b1000, 4'b0000);

    // Test 2: S pulse during N green; N served its minimum, then S.
    add_reset("t2_rst");
    add_startup("t2");
    add("t2_s_pulse",   1, 1'b1, 4'b0010, 1'b0, 2'd0, 8'h80, 4'b1000, 4'b0000);
    add("t2_n_min",    19, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h80, 4'b1000, 4'b0010);
    add("t2_n_yel",     8, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h40, 4'b1000, 4'b0010);
    add("t2_allred",    4, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 4'b0000, 4'b0010);
    add("t2_s_green",   8, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h08, 4'b0010, 4'b0000);

    // Test 3: N demand held with W waiting -> N runs exactly MAX_GREEN.
    add_reset("t3_rst");
    add_startup("t3");
    add("t3_req_on",    1, 1'b1, 4'b1001, 1'b0, 2'd0, 8'h80, 4'b1000, 4'b0000);
    add("t3_n_max",    79, 1'b1, 4'b1001, 1'b0, 2'd0, 8'h80, 4'b1000, 4'b0001);
    add("t3_n_yel",     8, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h40, 4'b1000, 4'b0001);
    add("t3_allred",    4, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 4'b0000, 4'b0001);
    add("t3_w_green",   8, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h02, 4'b0001, 4'b0000);

    // Test 4: E,S,W all pending -> served E, S, W in turn.
    add_reset("t4_rst");
    add_startup("t4");
    add("t4_pulse",     1, 1'b1, 4'b0111, 1'b0, 2'd0, 8'h80, 4'b1000, 4'b0000);
    add("t4_n_green",  19, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h80, 4'b1000, 4'b0111);
    add("t4_n_yel",     8, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h40, 4'b1000, 4'b0111);
    add("t4_ar1",       4, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 4'b0000, 4'b0111);
    add("t4_e_green",  20, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h20, 4'b0100, 4'b0011);
    add("t4_e_yel",     8, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h10, 4'b0100, 4'b0011);
    add("t4_ar2",       4, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 4'b0000, 4'b0011);
    add("t4_s_green",  20, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h08, 4'b0010, 4'b0001);
    add("t4_s_yel",     8, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h04, 4'b0010, 4'b0001);
    add("t4_ar3",       4, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 4'b0000, 4'b0001);
    add("t4_w_green",   8, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h02, 4'b0001, 4'b0000);

`ifdef PREEMPT_EN
    // Test 5: E green at elapsed=1, preempt toward S.
    add_reset("t5_rst");
    add_startup("t5");
    add("t5_e_pulse",   1, 1'b1, 4'b0100, 1'b0, 2'd0, 8'h80, 4'b1000, 4'b0000);
    add("t5_n_green",  19, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h80, 4'b1000, 4'b0100);
    add("t5_n_yel",     8, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h40, 4'b1000, 4'b0100);
    add("t5_ar1",       4, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 4'b0000, 4'b0100);
    add("t5_e_green",   4, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h20, 4'b0100, 4'b0000);
    add("t5_pre_on",    1, 1'b1, 4'b0000, 1'b1, 2'd2, 8'h20, 4'b0100, 4'b0000);
    add("t5_e_yel",     7, 1'b1, 4'b0000, 1'b1, 2'd2, 8'h10, 4'b0100, 4'b0000);
    add("t5_ar2",       4, 1'b1, 4'b0000, 1'b1, 2'd2, 8'h00, 4'b0000, 4'b0000);
    add("t5_s_hold",   12, 1'b1, 4'b0000, 1'b1, 2'd2, 8'h08, 4'b0010, 4'b0000);
`endif

    // Test 6: reset asserted during yellow, startup repeats.
    add_reset("t6_rst");
    add_startup("t6a");
    add("t6_s_pulse",   1, 1'b1, 4'b0010, 1'b0, 2'd0, 8'h80, 4'b1000, 4'b0000);
    add("t6_n_min",    19, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h80, 4'b1000, 4'b0010);
    add("t6_n_yel",     3, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h40, 4'b1000, 4'b0010);
    add("t6_mid_rst",   2, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h55, 4'b0000, 4'b0000);
    add_startup("t6b");
    add("t6_n_rest",    8, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h80, 4'b1000, 4'b0000);

    foreach (segs[i]) begin
      for (int c = 0; c < segs[i].cycles; c++) begin
        exp_t e;
        @(posedge clk);
        #1;
        reset = segs[i].rst;
        req   = segs[i].req;
`ifdef PREEMPT_EN
        preempt     = segs[i].pre;
        preempt_dir = segs[i].dir;
`endif
        e.name   = segs[i].name;
        e.lights = segs[i].lights;
        e.grant  = segs[i].grant;
        e.pend   = segs[i].pend;
        expq.push_back(e);
      end
    end

    @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", expq.size());
    end
    done = 1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
